// File: rtl/rom_bus_arbiter_pkg.sv
// Shared types and constants for the two-master ROM bus arbiter.
// State encoding, response bundle and default bus/watchdog sizing live here.
package rom_bus_arbiter_pkg;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int SEL_W       = 4;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_TCW     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    // Per-transfer termination seen by the granted master.
    typedef struct packed {
        logic ack;
        logic err;
    } resp_t;

    function automatic arb_state_t gnt_state(input logic idx);
        return idx ? ST_GNT1 : ST_GNT0;
    endfunction

endpackage

// File: rtl/rom_bus_arbiter_if.sv
// Wishbone signal bundle between the two CPU masters, the arbiter and the ROM slave.
// Handshake: a transfer is live while cyc&stb are high and ends on the cycle ack or err is high.
interface rom_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import rom_bus_arbiter_pkg::*;

    logic [AW-1:0]    m0_adr_i;
    logic [DW-1:0]    m0_dat_i;
    logic [SEL_W-1:0] m0_sel_i;
    logic             m0_we_i;
    logic             m0_stb_i;
    logic             m0_cyc_i;
    logic [DW-1:0]    m0_dat_o;
    logic             m0_ack_o;
    logic             m0_err_o;

    logic [AW-1:0]    m1_adr_i;
    logic [DW-1:0]    m1_dat_i;
    logic [SEL_W-1:0] m1_sel_i;
    logic             m1_we_i;
    logic             m1_stb_i;
    logic             m1_cyc_i;
    logic [DW-1:0]    m1_dat_o;
    logic             m1_ack_o;
    logic             m1_err_o;

    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SEL_W-1:0] s_sel_o;
    logic             s_we_o;
    logic             s_stb_o;
    logic             s_cyc_o;
    logic [DW-1:0]    s_dat_i;
    logic             s_ack_i;

    // Arbiter side: slave to both CPU masters, master towards the ROM.
    modport slave (
        input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_stb_i, m0_cyc_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_stb_i, m1_cyc_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
        input  s_dat_i, s_ack_i
    );

    // Environment side: the CPU masters and the ROM model.
    modport master (
        output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_stb_i, m0_cyc_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_stb_i, m1_cyc_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
        output s_dat_i, s_ack_i
    );

endinterface

// File: rtl/rom_bus_watchdog.sv
// Counts strobed cycles without a slave ack and flags a timeout on the last allowed cycle.
// The counter restarts after an ack, a timeout, a dropped strobe or an explicit clear.
module rom_bus_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int TCW     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic ack,
    input  logic clear,
    output logic timeout
);

    localparam logic [TCW-1:0] LAST = TCW'(TIMEOUT - 1);

    logic [TCW-1:0] cnt_q;

    // An ack arriving on the final cycle wins over the timeout.
    assign timeout = strobe & ~ack & (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || !strobe || ack || timeout) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TCW'(1);
        end
    end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Round-robin Wishbone arbiter sharing the instruction ROM between fetch (m0) and data (m1).
// Grants are registered and locked for the whole bus cycle; writes and stuck transfers end in err.
module rom_bus_arbiter
    import rom_bus_arbiter_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TCW     = DEF_TCW
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    rom_bus_arbiter_if.slave bus,
    output arb_state_t       dbg_state
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             last_gnt_q;
    logic             err_pending_q;

    logic             granted;
    logic             sel_cyc;
    logic             sel_stb;
    logic             sel_we;
    logic [AW-1:0]    sel_adr;
    logic [SEL_W-1:0] sel_sel;

    logic             rd_req;
    logic             wr_req;
    logic             timeout;
    logic             grant_change;
    resp_t            resp;
    logic [DW-1:0]    rd_data;
    logic             unused_dat;

    assign dbg_state  = state_q;
    assign rd_data    = bus.s_dat_i;
    assign unused_dat = ^{bus.m0_dat_i, bus.m1_dat_i};

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // last_gnt starts at 1 so that m0 wins the first tie after reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            last_gnt_q    <= 1'b1;
            err_pending_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && state_d != ST_IDLE) begin
                last_gnt_q <= (state_d == ST_GNT1);
            end
            err_pending_q <= wr_req;
        end
    end

    // Next-state logic: only IDLE can grant, so every handover has one IDLE bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = gnt_state(~last_gnt_q);
                end else if (bus.m0_cyc_i) begin
                    state_d = ST_GNT0;
                end else if (bus.m1_cyc_i) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: if (!bus.m0_cyc_i) state_d = ST_IDLE;
            ST_GNT1: if (!bus.m1_cyc_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_change = (state_q != state_d);

    // Select the granted master's request signals.
    always_comb begin
        granted = 1'b0;
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_sel = '0;
        unique case (state_q)
            ST_GNT0: begin
                granted = 1'b1;
                sel_cyc = bus.m0_cyc_i;
                sel_stb = bus.m0_stb_i;
                sel_we  = bus.m0_we_i;
                sel_adr = bus.m0_adr_i;
                sel_sel = bus.m0_sel_i;
            end
            ST_GNT1: begin
                granted = 1'b1;
                sel_cyc = bus.m1_cyc_i;
                sel_stb = bus.m1_stb_i;
                sel_we  = bus.m1_we_i;
                sel_adr = bus.m1_adr_i;
                sel_sel = bus.m1_sel_i;
            end
            default: ;
        endcase
    end

    // A dropped cyc abandons the transfer, so late slave acks fall out here too.
    assign rd_req = granted & sel_cyc & sel_stb & ~sel_we & ~err_pending_q;
    assign wr_req = granted & sel_cyc & sel_stb &  sel_we & ~err_pending_q;

    rom_bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TCW     (TCW)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_i),
        .strobe  (rd_req),
        .ack     (bus.s_ack_i),
        .clear   (grant_change),
        .timeout (timeout)
    );

    // err_pending and rd_req are exclusive, so ack and err never coincide.
    always_comb begin
        resp.ack = rd_req & bus.s_ack_i;
        resp.err = err_pending_q | timeout;
    end

    // Output logic: slave-side routing and per-master responses.
    always_comb begin
        bus.s_adr_o  = '0;
        bus.s_sel_o  = '0;
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_dat_o  = '0;
        bus.m0_dat_o = rd_data;
        bus.m1_dat_o = rd_data;
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        if (granted) begin
            bus.s_adr_o = sel_adr;
            bus.s_sel_o = sel_sel;
            bus.s_cyc_o = sel_cyc;
            bus.s_stb_o = rd_req & ~timeout;
        end
        unique case (state_q)
            ST_GNT0: begin
                bus.m0_ack_o = resp.ack;
                bus.m0_err_o = resp.err;
            end
            ST_GNT1: begin
                bus.m1_ack_o = resp.ack;
                bus.m1_err_o = resp.err;
            end
            default: ;
        endcase
    end

endmodule
